mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the register file and consumes its two read ports (rs_data, rt_data) as operands.
- Holds the architectural HI/LO registers, which feed the MFHI/MFLO writeback path into the register file.
- Runs a 32-iteration shift-add multiply or restoring divide, with a start/busy/done handshake toward the control unit.

---
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit.sv | 112 +++++++++++
 tb/tb_mul_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand, HI/LO and start/busy/done bundle between the control unit and the multiply/divide unit.
// master = issuing control side; slave = the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wr_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO; 32 cycles from the start edge to HI/LO valid.
// No backpressure: start is only sampled in IDLE, and a start seen while busy is dropped.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              is_div, neg_q, neg_r, done_q;
  logic [2*XLEN-1:0] acc, acc_nxt, prod_fix;
  logic [XLEN-1:0]   opb, quo_fix, rem_fix, hi_q, lo_q;
  logic [XLEN-1:0]   mag_rs, mag_rt;
  logic [XLEN:0]     msum, rsh;
  logic              sgn, accept, last, no_borrow;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(1));
  assign sgn    = ~bus.op[0];
  assign mag_rs = (sgn && bus.rs_data[XLEN-1]) ? -bus.rs_data : bus.rs_data;
  assign mag_rt = (sgn && bus.rt_data[XLEN-1]) ? -bus.rt_data : bus.rt_data;

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {upper,multiplier} for multiply and {remainder,quotient} for divide
  always_comb begin
    msum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    rsh       = acc[2*XLEN-1:XLEN-1];
    no_borrow = (rsh >= {1'b0, opb});
    acc_nxt   = {1'b0, acc[2*XLEN-1:1]};
    if (is_div) begin
      if (no_borrow) acc_nxt = {rsh[XLEN-1:0] - opb, acc[XLEN-2:0], 1'b1};
      else           acc_nxt = {rsh[XLEN-1:0],       acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {msum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    quo_fix  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_fix  = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= last;
      if (accept) begin
        cnt    <= CW'(XLEN);
        is_div <= bus.op[1];
        neg_q  <= sgn & (bus.rs_data[XLEN-1] ^ bus.rt_data[XLEN-1]);
        neg_r  <= sgn & bus.rs_data[XLEN-1];
        if (bus.op[1]) begin
          acc <= {{XLEN{1'b0}}, mag_rs};
          opb <= mag_rt;
        end else begin
          acc <= {{XLEN{1'b0}}, mag_rt};
          opb <= mag_rs;
        end
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        acc <= acc_nxt;
        if (last) begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*XLEN-1:XLEN];
            lo_q <= prod_fix[XLEN-1:0];
          end
        end
      end else begin
        // MTHI/MTLO only land in IDLE without a competing start
        if (bus.hi_we) hi_q <= bus.wr_data;
        if (bus.lo_we) lo_q <= bus.wr_data;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random ops against an arithmetic model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(32)) bus ();
  mul_div_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // {HI,LO} as defined by the architecture, from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic        s;
    case (op)
      2'd0: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        s  = (op == 2'd2);
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (mb == 0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_data = rs; bus.rt_data = rt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wr_data = 0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_lo: got %h want 0", bus.lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int cyc, bn;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL multu_busy_start: got %b want 1", bus.busy); end
    wait_done(cyc, bn);
    total++; if (cyc != 32) begin bad++; $display("FAIL multu_latency: got %0d want 32", cyc); end
    total++; if (bn != 32) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 32", bn); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL multu_busy_with_done: got %b want 0", bus.busy); end
    total++; if (bus.hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    total++; if (bus.lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, bn);
    total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    total++; if (bus.lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", bus.lo); end
    bus.start = 1'b1; bus.op = 2'd2; bus.rs_data = 32'hFFFF_FFF9; bus.rt_data = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", bus.busy); end
    wait_done(cyc, bn);
    total++; if (cyc != 32) begin bad++; $display("FAIL b2b_latency: got %0d want 32", cyc); end
    total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
    total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
  endtask

  task automatic test_div_edges();
    int cyc, bn;
    issue(2'd3, 32'd100, 32'd0);
    wait_done(cyc, bn);
    total++; if (cyc != 32) begin bad++; $display("FAIL divz_latency: got %0d want 32", cyc); end
    total++; if (bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
    total++; if (bus.hi !== 32'h0000_0064) begin bad++; $display("FAIL divz_hi: got %h want 00000064", bus.hi); end
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bn);
    total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo: got %h want 80000000", bus.lo); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL ovf_hi: got %h want 0", bus.hi); end
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    issue(2'd1, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.rs_data = 32'd77; bus.rt_data = 32'd99;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", pulses); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL ignore_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'd30) begin bad++; $display("FAIL ignore_lo: got %h want 1e", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    int pulses = 0;
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    total++; if (bus.hi !== 32'h1234) begin bad++; $display("FAIL mthi_pre: got %h want 1234", bus.hi); end
    total++; if (bus.lo !== 32'h1234) begin bad++; $display("FAIL mtlo_pre: got %h want 1234", bus.lo); end
    issue(2'd1, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL midrst_hi: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL midrst_lo: got %h want 0", bus.lo); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", pulses); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL midrst_lo_after: got %h want 0", bus.lo); end
  endtask

  task automatic test_mt();
    int cyc, bn;
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wr_data = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.lo_we = 1'b0;
    total++; if (bus.lo !== 32'hA5A5_A5A5) begin bad++; $display("FAIL mtlo: got %h want a5a5a5a5", bus.lo); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL mtlo_hi_untouched: got %h want 0", bus.hi); end
    issue(2'd1, 32'd2, 32'd3);
    repeat (3) @(negedge clk);
    bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL mthi_busy: got %h want 0", bus.hi); end
    total++; if (bus.lo !== 32'hA5A5_A5A5) begin bad++; $display("FAIL lo_hold_run: got %h want a5a5a5a5", bus.lo); end
    wait_done(cyc, bn);
    total++; if (bus.lo !== 32'd6) begin bad++; $display("FAIL mt_run_lo: got %h want 6", bus.lo); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.rs_data = 32'h0001_0000; bus.rt_data = 32'h0003_0000;
    bus.hi_we = 1'b1; bus.wr_data = 32'h0000_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL start_wins_busy: got %b want 1", bus.busy); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL start_wins_hi: got %h want 0", bus.hi); end
    wait_done(cyc, bn);
    total++; if (bus.hi !== 32'h3) begin bad++; $display("FAIL start_wins_res_hi: got %h want 3", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL start_wins_res_lo: got %h want 0", bus.lo); end
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(0, 5))
      0: return allow_zero ? 32'h0 : 32'h1;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int cyc, bn;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic [63:0] exp;
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      rs  = pick(1'b1);
      rt  = pick(1'b1);
      exp = model(op, rs, rt);
      issue(op, rs, rt);
      wait_done(cyc, bn);
      total++; if (cyc != 32) begin bad++; $display("FAIL rnd_latency op=%0d: got %0d want 32", op, cyc); end
      total++; if (bus.hi !== exp[63:32]) begin bad++; $display("FAIL rnd_hi op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, bus.hi, exp[63:32]); end
      total++; if (bus.lo !== exp[31:0]) begin bad++; $display("FAIL rnd_lo op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, bus.lo, exp[31:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_edges();
    test_start_ignored();
    test_reset_midop();
    test_mt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
